fp_to_int: RTL and testbench



---
 rtl/fp_pkg.sv | 11 +
 rtl/fp_classify.sv | 22 ++
 rtl/fp_to_int.sv | 110 +++++++++++
 tb/tb_fp_to_int.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared FP32 field widths, saturation constants and enums for the FP units.
package fp_pkg;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int EXP_BIAS = 127;
  localparam logic [31:0] INT32_MAX  = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN  = 32'h8000_0000;
  localparam logic [31:0] UINT32_MAX = 32'hFFFF_FFFF;
  typedef enum logic [2:0] {IDLE, DECODE, ALIGN, ROUND, DONE} state_e;
  typedef enum logic [2:0] {CLS_ZERO, CLS_DENORM, CLS_NORMAL, CLS_INF, CLS_NAN} cls_e;
endpackage

// File: rtl/fp_classify.sv
// fp_classify: combinational FP32 classifier giving class, sign, unbiased exponent and mantissa.
module fp_classify
  import fp_pkg::*;
(
  input  logic [31:0]       fp,
  output cls_e              cls,
  output logic              sign,
  output logic signed [9:0] uexp,
  output logic [23:0]       mant
);
  logic [EXP_W-1:0]  e_raw;
  logic [FRAC_W-1:0] frac;
  assign e_raw = fp[30:23];
  assign frac  = fp[22:0];
  assign sign  = fp[31];
  assign uexp  = 10'({2'b00, e_raw}) - 10'(EXP_BIAS);
  assign mant  = {e_raw != '0, frac};
  always_comb begin
    cls = e_raw == '1 ? (frac != '0 ? CLS_NAN : CLS_INF) :
          e_raw == '0 ? (frac != '0 ? CLS_DENORM : CLS_ZERO) : CLS_NORMAL;
  end
endmodule

// File: rtl/fp_to_int.sv
// fp_to_int: multi-cycle FP32 to INT32/UINT32 converter with iterative alignment and RISC-V flags.
module fp_to_int
  import fp_pkg::*;
#(
  parameter int SHIFT_PER_CYCLE = 32
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_signed,
  input  logic        in_rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_invalid,
  output logic        out_inexact
);
  localparam logic [5:0] SPC = 6'(SHIFT_PER_CYCLE);
  state_e state_q, state_d;
  logic [31:0] op_q, op_d, data_q, data_d, res;
  logic sg_q, sg_d, rm_q, rm_d, nv_q, nv_d, nx_q, nx_d;
  logic [33:0] val_q, val_d, mask, rsh;
  logic [5:0] rem_q, rem_d, step, dec_rem;
  logic [32:0] mag;
  logic inc, big, sneg, ovf, uneg, accept;
  cls_e cls;
  logic sign;
  logic signed [9:0] e;
  logic [23:0] mant;

  // The held operand stays stable for the whole operation, so classification is reused in every state.
  fp_classify u_cls (.fp(op_q), .cls(cls), .sign(sign), .uexp(e), .mant(mant));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = in_valid ? DECODE : IDLE;
      DECODE:  state_d = ALIGN;
      ALIGN:   state_d = rem_q <= SPC ? ROUND : ALIGN;
      ROUND:   state_d = DONE;
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept  = state_q == IDLE && in_valid;
    op_d    = accept ? in_data : op_q;
    sg_d    = accept ? in_signed : sg_q;
    rm_d    = accept ? in_rm : rm_q;
    big     = cls == CLS_NORMAL && e >= 10'sd32;
    dec_rem = cls != CLS_NORMAL || big ? 6'd0 : e >= 10'sd24 ? 6'(e - 10'sd23) :
              e < -10'sd2 ? 6'd25 : 6'(10'sd23 - e);
    step    = rem_q > SPC ? SPC : rem_q;
    // Sticky collects everything at or below the new sticky position, including the old sticky.
    mask    = (34'd1 << (step + 6'd1)) - 34'd1;
    rsh     = val_q >> step;
    val_d   = state_q == DECODE ? (cls == CLS_NORMAL ? {8'd0, mant, 2'd0} : {33'd0, cls == CLS_DENORM}) :
              state_q == ALIGN ? (e >= 10'sd24 ? val_q << step : {rsh[33:1], |(val_q & mask)}) : val_q;
    rem_d   = state_q == DECODE ? dec_rem : state_q == ALIGN ? rem_q - step : rem_q;
    inc     = rm_q & val_q[1] & (val_q[0] | val_q[2]);
    mag     = {1'b0, val_q[33:2]} + {32'd0, inc};
    sneg    = sign && cls != CLS_NAN;
    ovf     = cls == CLS_INF || cls == CLS_NAN || big ||
              (sg_q ? mag > {1'b0, INT32_MAX} && !(sign && mag == {1'b0, INT32_MIN}) : mag[32]);
    uneg    = !sg_q && sign && mag != '0;
    res     = ovf ? (sg_q ? (sneg ? INT32_MIN : INT32_MAX) : (sneg ? 32'd0 : UINT32_MAX)) :
              uneg ? 32'd0 : sg_q && sign ? -mag[31:0] : mag[31:0];
    data_d  = state_q == ROUND ? res : data_q;
    nv_d    = state_q == ROUND ? ovf | uneg : nv_q;
    nx_d    = state_q == ROUND ? !(ovf | uneg) & (val_q[1] | val_q[0]) : nx_q;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      op_q   <= '0;
      sg_q   <= 1'b0;
      rm_q   <= 1'b0;
      val_q  <= '0;
      rem_q  <= '0;
      data_q <= '0;
      nv_q   <= 1'b0;
      nx_q   <= 1'b0;
    end else begin
      op_q   <= op_d;
      sg_q   <= sg_d;
      rm_q   <= rm_d;
      val_q  <= val_d;
      rem_q  <= rem_d;
      data_q <= data_d;
      nv_q   <= nv_d;
      nx_q   <= nx_d;
    end
  end

  always_comb begin
    in_ready    = state_q == IDLE;
    out_valid   = state_q == DONE;
    out_data    = data_q;
    out_invalid = nv_q;
    out_inexact = nx_q;
  end
endmodule

// File: tb/tb_fp_to_int.sv
// tb_fp_to_int: vector table, random model comparison and handshake/reset sequences for fp_to_int.
module tb_fp_to_int;
  logic wb_clk_i = 1'b0, wb_rst_i = 1'b1;
  logic in_valid = 1'b0, in_valid4 = 1'b0, in_signed = 1'b0, in_rm = 1'b0;
  logic out_ready = 1'b0, out_ready4 = 1'b0;
  logic [31:0] in_data = '0;
  logic in_ready, out_valid, out_invalid, out_inexact;
  logic in_ready4, out_valid4, out_invalid4, out_inexact4;
  logic [31:0] out_data, out_data4;
  int n_chk = 0, n_err = 0;

  fp_to_int dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_signed(in_signed), .in_rm(in_rm), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_invalid(out_invalid), .out_inexact(out_inexact)
  );
  fp_to_int #(.SHIFT_PER_CYCLE(4)) dut4 (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data), .in_signed(in_signed), .in_rm(in_rm), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_data(out_data4), .out_invalid(out_invalid4), .out_inexact(out_inexact4)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] d;
    logic        sg;
    logic        rm;
    logic [31:0] r;
    logic        nv;
    logic        nx;
  } vec_t;

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Exact real-valued conversion: value = mant * 2^(e-23), scaled by 2^39 for the fraction.
  function automatic logic [33:0] model(input logic [31:0] d, input logic sg, input logic rm);
    int ex, e;
    logic sn, nx;
    logic [22:0] fr;
    longint unsigned m, mag, sc, ip, f;
    ex = int'(d[30:23]);
    e  = ex - 127;
    sn = d[31];
    fr = d[22:0];
    m  = {40'd0, 1'b1, fr};
    nx = 1'b0;
    if (ex == 255)
      return {2'b10, (fr != 0 || !sn) ? (sg ? 32'h7FFFFFFF : 32'hFFFFFFFF) : (sg ? 32'h80000000 : 32'h0)};
    if (ex == 0) return {1'b0, fr != 0, 32'h0};
    if (e >= 32) mag = 64'h10_0000_0000;
    else if (e >= 23) mag = m << (e - 23);
    else if (e < -1) begin
      mag = 0;
      nx = 1'b1;
    end else begin
      sc = m << (e + 16);
      ip = sc >> 39;
      f  = sc & ((64'd1 << 39) - 1);
      nx = f != 0;
      if (rm && (f > (64'd1 << 38) || (f == (64'd1 << 38) && ip[0]))) ip++;
      mag = ip;
    end
    if (sg) begin
      if (mag > (sn ? 64'h8000_0000 : 64'h7FFF_FFFF)) return {2'b10, sn ? 32'h80000000 : 32'h7FFFFFFF};
      return {1'b0, nx, sn ? 32'(-mag) : 32'(mag)};
    end
    if (mag >= 64'h1_0000_0000) return {2'b10, sn ? 32'h0 : 32'hFFFFFFFF};
    if (sn && mag != 0) return {2'b10, 32'h0};
    return {1'b0, nx, 32'(mag)};
  endfunction

  // Edges from accept to out_valid for the 4-bit-per-cycle instance.
  function automatic int lat4(input logic [31:0] d);
    int ex, e, sh;
    ex = int'(d[30:23]);
    e  = ex - 127;
    if (ex == 0 || ex == 255 || e >= 32) sh = 0;
    else if (e >= 24) sh = e - 23;
    else sh = (23 - e > 25) ? 25 : 23 - e;
    return 2 + (sh == 0 ? 1 : (sh + 3) / 4);
  endfunction

  task automatic run_op(input logic [31:0] d, input logic sg, input logic rm,
                        output logic [33:0] q0, output logic [33:0] q4, output int l0, output int l4);
    @(negedge wb_clk_i);
    in_data = d;
    in_signed = sg;
    in_rm = rm;
    in_valid = 1'b1;
    in_valid4 = 1'b1;
    @(posedge wb_clk_i);
    #1;
    in_valid = 1'b0;
    in_valid4 = 1'b0;
    l0 = -1;
    l4 = -1;
    q0 = '0;
    q4 = '0;
    for (int c = 1; c <= 40 && (l0 < 0 || l4 < 0); c++) begin
      @(posedge wb_clk_i);
      #1;
      if (l0 < 0 && out_valid) begin
        l0 = c;
        q0 = {out_invalid, out_inexact, out_data};
      end
      if (l4 < 0 && out_valid4) begin
        l4 = c;
        q4 = {out_invalid4, out_inexact4, out_data4};
      end
    end
    out_ready = 1'b1;
    out_ready4 = 1'b1;
    @(posedge wb_clk_i);
    #1;
    out_ready = 1'b0;
    out_ready4 = 1'b0;
  endtask

  task automatic check_op(input string nm, input logic [31:0] d, input logic sg, input logic rm,
                          input logic [33:0] exp);
    logic [33:0] q0, q4;
    int l0, l4;
    run_op(d, sg, rm, q0, q4, l0, l4);
    chk({nm, " res32"}, 40'(q0), 40'(exp));
    chk({nm, " res4"}, 40'(q4), 40'(exp));
    chk({nm, " lat32"}, 40'(l0), 40'(3));
    chk({nm, " lat4"}, 40'(l4), 40'(lat4(d)));
  endtask

  initial begin
    vec_t vecs[26];
    logic got;
    logic [31:0] rd;
    logic [7:0] ex;
    logic sg, rm;
    vecs = '{
      '{32'h3FC00000, 1'b1, 1'b1, 32'h00000002, 1'b0, 1'b1},
      '{32'h3FC00000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b1},
      '{32'h40200000, 1'b1, 1'b1, 32'h00000002, 1'b0, 1'b1},
      '{32'hC2F60000, 1'b1, 1'b0, 32'hFFFFFF85, 1'b0, 1'b0},
      '{32'hC2F60000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0},
      '{32'h4F000000, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0},
      '{32'h4F000000, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0},
      '{32'hCF000000, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b0},
      '{32'h7F800000, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0},
      '{32'h3F800000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0},
      '{32'hFF800000, 1'b1, 1'b0, 32'h80000000, 1'b1, 1'b0},
      '{32'hFF800000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0},
      '{32'h7FC00000, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0},
      '{32'h80000000, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0},
      '{32'h00000001, 1'b1, 1'b1, 32'h00000000, 1'b0, 1'b1},
      '{32'h3F000000, 1'b1, 1'b1, 32'h00000000, 1'b0, 1'b1},
      '{32'h3F400000, 1'b1, 1'b1, 32'h00000001, 1'b0, 1'b1},
      '{32'hBFC00000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0},
      '{32'hBF000000, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b1},
      '{32'h4F800000, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0},
      '{32'h4F7FFFFF, 1'b0, 1'b0, 32'hFFFFFF00, 1'b0, 1'b0},
      '{32'hCF000001, 1'b1, 1'b0, 32'h80000000, 1'b1, 1'b0},
      '{32'h40600000, 1'b1, 1'b1, 32'h00000004, 1'b0, 1'b1},
      '{32'h3EFFFFFF, 1'b1, 1'b1, 32'h00000000, 1'b0, 1'b1},
      '{32'h3FFFFFFF, 1'b1, 1'b1, 32'h00000002, 1'b0, 1'b1},
      '{32'hC0200000, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b1}
    };
    #1;
    chk("reset dut32", {in_ready, out_valid, out_invalid, out_inexact, out_data}, {4'b1000, 32'h0});
    chk("reset dut4", {in_ready4, out_valid4, out_invalid4, out_inexact4, out_data4}, {4'b1000, 32'h0});
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;

    for (int i = 0; i < 26; i++)
      check_op($sformatf("vec%0d", i), vecs[i].d, vecs[i].sg, vecs[i].rm, {vecs[i].nv, vecs[i].nx, vecs[i].r});

    for (int i = 0; i < 250; i++) begin
      rd = $urandom;
      ex = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(100, 160)) : rd[30:23];
      rd[30:23] = ex;
      sg = 1'($urandom);
      rm = 1'($urandom);
      check_op($sformatf("rnd%0d %h s%0d r%0d", i, rd, sg, rm), rd, sg, rm, model(rd, sg, rm));
    end

    // Backpressure: result must hold while a second operand waits unaccepted.
    @(negedge wb_clk_i);
    in_data = 32'h7FC00000;
    in_signed = 1'b1;
    in_rm = 1'b0;
    in_valid = 1'b1;
    @(posedge wb_clk_i);
    #1 in_data = 32'h3F800000;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(posedge wb_clk_i);
      #1 got = out_valid;
    end
    chk("bp valid", 40'(got), 40'(1));
    for (int c = 0; c < 5; c++) begin
      @(posedge wb_clk_i);
      #1;
      chk("bp hold", {in_ready, out_valid, out_invalid, out_inexact, out_data}, {4'b0110, 32'h7FFFFFFF});
    end
    out_ready = 1'b1;
    @(posedge wb_clk_i);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("bp release", {in_ready, out_valid}, 40'b10);
    repeat (4) @(posedge wb_clk_i);
    #1 chk("bp no second", {in_ready, out_valid}, 40'b10);

    // Asynchronous reset while the iterative instance is still aligning.
    @(negedge wb_clk_i);
    in_data = 32'h3F800000;
    in_signed = 1'b1;
    in_valid4 = 1'b1;
    @(posedge wb_clk_i);
    #1 in_valid4 = 1'b0;
    repeat (2) @(posedge wb_clk_i);
    #2 chk("align busy", {in_ready4, out_valid4}, 40'b00);
    wb_rst_i = 1'b1;
    #1 chk("rst mid align", {in_ready4, out_valid4, out_invalid4, out_inexact4, out_data4}, {4'b1000, 32'h0});
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    check_op("after rst", 32'h3FC00000, 1'b1, 1'b1, {2'b01, 32'h2});

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
